// File: rtl/regfile_writeback.sv
// Write-back controller for the 32x32 register file: arbitrates ALU and load
// results onto the single write port, queues colliding loads, tracks busy regs.
module regfile_writeback #(
    parameter int LDQ_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        stall,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [4:0]  ld_rd,
    input  logic [31:0] ld_data,
    output logic [4:0]  Rd_addr,
    output logic [31:0] Write_Rd_data,
    output logic        writeControl,
    output logic [31:0] busy
);

    logic [4:0]  q_rd_r   [0:LDQ_DEPTH-1];
    logic [31:0] q_data_r [0:LDQ_DEPTH-1];
    logic        q_head_r;
    logic        q_tail_r;
    logic [1:0]  q_count_r;

    logic        ld_take_s;
    logic        alu_win_s;
    logic        push_s;
    logic        pop_s;
    logic        wr_en_s;
    logic [4:0]  wr_rd_s;
    logic [31:0] wr_data_s;
    logic        issue_set_s;
    logic [31:0] busy_nxt_s;

    // x0 is never tracked, so a lookup of register 0 can never hazard
    function automatic logic busy_hit(input logic [31:0] vec, input logic [4:0] addr);
        busy_hit = (addr != 5'd0) ? vec[addr] : 1'b0;
    endfunction

    assign ld_ready  = (q_count_r < 2'(LDQ_DEPTH));
    assign stall     = busy_hit(busy, rs1_addr) | busy_hit(busy, rs2_addr) |
                       busy_hit(busy, issue_rd);
    assign ld_take_s = ld_valid & ld_ready & (ld_rd != 5'd0);
    assign alu_win_s = alu_valid & (alu_rd != 5'd0);
    assign issue_set_s = issue_valid & ~stall & (issue_rd != 5'd0);

    // Write-port arbitration: ALU, then queued load, then a bypassing load
    always_comb begin
        wr_en_s   = 1'b0;
        wr_rd_s   = 5'd0;
        wr_data_s = 32'd0;
        push_s    = 1'b0;
        pop_s     = 1'b0;
        if (alu_win_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = alu_rd;
            wr_data_s = alu_data;
            push_s    = ld_take_s;
        end else if (q_count_r != 2'd0) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = q_rd_r[q_head_r];
            wr_data_s = q_data_r[q_head_r];
            pop_s     = 1'b1;
            push_s    = ld_take_s;
        end else if (ld_take_s) begin
            wr_en_s   = 1'b1;
            wr_rd_s   = ld_rd;
            wr_data_s = ld_data;
        end else begin
            wr_en_s   = 1'b0;
        end
    end

    // Scoreboard next state: the retiring write clears first, a new issue sets after
    always_comb begin
        busy_nxt_s = busy;
        if (writeControl) begin
            busy_nxt_s[Rd_addr] = 1'b0;
        end else begin
            busy_nxt_s = busy;
        end
        if (issue_set_s) begin
            busy_nxt_s[issue_rd] = 1'b1;
        end else begin
            busy_nxt_s[0] = 1'b0;
        end
        busy_nxt_s[0] = 1'b0;
    end

    // Write-port and scoreboard registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            writeControl  <= 1'b0;
            Rd_addr       <= 5'd0;
            Write_Rd_data <= 32'd0;
            busy          <= 32'd0;
        end else begin
            writeControl <= wr_en_s;
            busy         <= busy_nxt_s;
            if (wr_en_s) begin
                Rd_addr       <= wr_rd_s;
                Write_Rd_data <= wr_data_s;
            end
        end
    end

    // Load-return FIFO: circular buffer with independent push and pop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q_head_r  <= 1'b0;
            q_tail_r  <= 1'b0;
            q_count_r <= 2'd0;
            for (int i = 0; i < LDQ_DEPTH; i++) begin
                q_rd_r[i]   <= 5'd0;
                q_data_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                q_rd_r[q_tail_r]   <= ld_rd;
                q_data_r[q_tail_r] <= ld_data;
                q_tail_r           <= ~q_tail_r;
            end
            if (pop_s) begin
                q_head_r <= ~q_head_r;
            end
            case ({push_s, pop_s})
                2'b10:   q_count_r <= q_count_r + 2'd1;
                2'b01:   q_count_r <= q_count_r - 2'd1;
                default: q_count_r <= q_count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Self-checking bench for regfile_writeback: directed vector table, reset
// sequence and randomized traffic against a queue-based reference model.
module tb_regfile_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd, rs1_addr, rs2_addr;
    logic        stall;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic [4:0]  Rd_addr;
    logic [31:0] Write_Rd_data;
    logic        writeControl;
    logic [31:0] busy;

    int n_tests = 0;
    int n_fail  = 0;

    regfile_writeback #(.LDQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .stall(stall),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .Rd_addr(Rd_addr), .Write_Rd_data(Write_Rd_data),
        .writeControl(writeControl), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: busy bit per register, pending loads as a queue
    typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
    bit          m_busy [32];
    ent_t        m_q [$];
    logic        m_wc;
    logic [4:0]  m_rd;
    logic [31:0] m_data;

    function automatic logic [31:0] m_busy_vec();
        logic [31:0] v = 32'd0;
        for (int i = 1; i < 32; i++) v[i] = m_busy[i];
        return v;
    endfunction

    function automatic logic m_stall();
        return (rs1_addr != 5'd0 && m_busy[rs1_addr]) ||
               (rs2_addr != 5'd0 && m_busy[rs2_addr]) ||
               (issue_rd != 5'd0 && m_busy[issue_rd]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_q.delete();
        m_wc = 1'b0; m_rd = 5'd0; m_data = 32'd0;
    endtask

    task automatic model_step();
        bit   acc = ld_valid && (m_q.size() < 2);
        bit   st  = m_stall();
        ent_t e;
        if (m_wc) m_busy[m_rd] = 1'b0;
        if (issue_valid && !st && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        e.rd = ld_rd; e.d = ld_data;
        if (alu_valid && alu_rd != 5'd0) begin
            m_wc = 1'b1; m_rd = alu_rd; m_data = alu_data;
            if (acc && ld_rd != 5'd0) m_q.push_back(e);
        end else if (m_q.size() > 0) begin
            ent_t h = m_q.pop_front();
            m_wc = 1'b1; m_rd = h.rd; m_data = h.d;
            if (acc && ld_rd != 5'd0) m_q.push_back(e);
        end else if (acc && ld_rd != 5'd0) begin
            m_wc = 1'b1; m_rd = ld_rd; m_data = ld_data;
        end else begin
            m_wc = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // One cycle: combinational checks, edge, model update, registered checks
    task automatic tick();
        #1;
        chk("stall", {31'd0, stall}, {31'd0, m_stall()});
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, (m_q.size() < 2)});
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("writeControl", {31'd0, writeControl}, {31'd0, m_wc});
        if (m_wc) begin
            chk("Rd_addr", {27'd0, Rd_addr}, {27'd0, m_rd});
            chk("Write_Rd_data", Write_Rd_data, m_data);
        end
        chk("busy", busy, m_busy_vec());
    endtask

    task automatic quiet();
        issue_valid = 1'b0; issue_rd = 5'd0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    endtask

    typedef struct {
        logic iv; logic [4:0] ird, rs1, rs2;
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic lv; logic [4:0] lrd; logic [31:0] ldd;
        logic e_stall, e_ldr, e_wc; logic [4:0] e_rd; logic [31:0] e_data, e_busy;
    } vec_t;
    vec_t vt [26];

    initial begin
        // iv ird rs1 rs2 | av ard ad | lv lrd ld | stall ldr wc rd data busy
        vt[0]  = '{1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd0,  32'h0,        32'h20};
        vt[1]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF, 32'h20};
        vt[2]  = '{1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vt[3]  = '{1'b0, 5'd0, 5'd5, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
        vt[4]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd3,  32'h11,       1'b1, 5'd7,  32'h22,   1'b0, 1'b1, 1'b1, 5'd3,  32'h11,       32'h0};
        vt[5]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd7,  32'h22,       32'h0};
        vt[6]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd7,  32'h22,       32'h0};
        vt[7]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd10, 32'hA0,       1'b1, 5'd11, 32'hB0,   1'b0, 1'b1, 1'b1, 5'd10, 32'hA0,       32'h0};
        vt[8]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd12, 32'hA1,       1'b1, 5'd13, 32'hB1,   1'b0, 1'b1, 1'b1, 5'd12, 32'hA1,       32'h0};
        vt[9]  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd14, 32'hA2,       1'b1, 5'd15, 32'hB2,   1'b0, 1'b0, 1'b1, 5'd14, 32'hA2,       32'h0};
        vt[10] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd16, 32'hA3,       1'b1, 5'd15, 32'hB2,   1'b0, 1'b0, 1'b1, 5'd16, 32'hA3,       32'h0};
        vt[11] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'hB2,   1'b0, 1'b0, 1'b1, 5'd11, 32'hB0,       32'h0};
        vt[12] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd15, 32'hB2,   1'b0, 1'b1, 1'b1, 5'd13, 32'hB1,       32'h0};
        vt[13] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd15, 32'hB2,       32'h0};
        vt[14] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd15, 32'hB2,       32'h0};
        vt[15] = '{1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd15, 32'hB2,       32'h200};
        vt[16] = '{1'b1, 5'd9, 5'd0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd15, 32'hB2,       32'h200};
        vt[17] = '{1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd15, 32'hB2,       32'h200};
        vt[18] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9,  32'h99,       1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b1, 5'd9,  32'h99,       32'h200};
        vt[19] = '{1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b0, 5'd9,  32'h99,       32'h0};
        vt[20] = '{1'b0, 5'd0, 5'd0, 5'd9, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd9,  32'h99,       32'h0};
        vt[21] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd9,  32'h99,       32'h0};
        vt[22] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h55,   1'b0, 1'b1, 1'b0, 5'd9,  32'h99,       32'h0};
        vt[23] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd9,  32'h99,       32'h0};
        vt[24] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b1, 5'd20, 32'h1234, 1'b0, 1'b1, 1'b1, 5'd20, 32'h1234,     32'h0};
        vt[25] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,    1'b0, 1'b1, 1'b0, 5'd20, 32'h1234,     32'h0};

        quiet();
        rst = 1'b0;
        model_reset();
        #3;
        chk("rst_writeControl", {31'd0, writeControl}, 32'd0);
        chk("rst_Rd_addr", {27'd0, Rd_addr}, 32'd0);
        chk("rst_data", Write_Rd_data, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Directed vector table
        for (int i = 0; i < 26; i++) begin
            issue_valid = vt[i].iv; issue_rd = vt[i].ird;
            rs1_addr = vt[i].rs1; rs2_addr = vt[i].rs2;
            alu_valid = vt[i].av; alu_rd = vt[i].ard; alu_data = vt[i].ad;
            ld_valid = vt[i].lv; ld_rd = vt[i].lrd; ld_data = vt[i].ldd;
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, stall}, {31'd0, vt[i].e_stall});
            chk($sformatf("vec%0d_ld_ready", i), {31'd0, ld_ready}, {31'd0, vt[i].e_ldr});
            tick();
            chk($sformatf("vec%0d_wc", i), {31'd0, writeControl}, {31'd0, vt[i].e_wc});
            chk($sformatf("vec%0d_rd", i), {27'd0, Rd_addr}, {27'd0, vt[i].e_rd});
            chk($sformatf("vec%0d_data", i), Write_Rd_data, vt[i].e_data);
            chk($sformatf("vec%0d_busy", i), busy, vt[i].e_busy);
        end

        // Reset mid-stream with two loads queued and a register busy
        quiet(); issue_valid = 1'b1; issue_rd = 5'd4;
        tick();
        quiet(); alu_valid = 1'b1; alu_rd = 5'd21; alu_data = 32'hC1;
        ld_valid = 1'b1; ld_rd = 5'd22; ld_data = 32'hD1;
        tick();
        alu_rd = 5'd23; alu_data = 32'hC2; ld_rd = 5'd24; ld_data = 32'hD2;
        tick();
        quiet();
        chk("pre_rst_ld_ready", {31'd0, ld_ready}, 32'd0);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_writeControl", {31'd0, writeControl}, 32'd0);
        chk("mid_rst_busy", busy, 32'd0);
        chk("mid_rst_ld_ready", {31'd0, ld_ready}, 32'd1);
        chk("mid_rst_Rd_addr", {27'd0, Rd_addr}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_no_write", {31'd0, writeControl}, 32'd0);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            issue_valid = ($urandom_range(0, 2) == 0);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1_addr    = 5'($urandom_range(0, 7));
            rs2_addr    = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 1) == 1);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            ld_valid    = ($urandom_range(0, 1) == 1);
            ld_rd       = 5'($urandom_range(0, 7));
            ld_data     = $urandom;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
